mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/mem_arb_starve_cnt.sv | 43 ++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline memory arbiter: FSM encoding,
// default starvation limit and a counter-width helper.
package pipeline_pkg;

   localparam int STARVE_MAX_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } arb_state_t;

   // Width needed to hold values 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts MEM grants that overtook a waiting IF request. Saturates at
// STARVE_MAX; once saturated the arbiter forces the next grant to IF.
module mem_arb_starve_cnt
   import pipeline_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CNT_W = cnt_width(STARVE_MAX);
   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment; increment stops at the saturation value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != SAT_VAL)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat = (cnt_q == SAT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage (IF) and the
// load/store stage (MEM). MEM normally wins a conflict, but after
// STARVE_MAX consecutive MEM grants over a waiting IF, IF is served.
module mem_arbiter
   import pipeline_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_stall,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_valid,
   output logic        mem_stall,
   output logic        ram_en,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready
);

   arb_state_t  state_q, state_d;

   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdata_q, ram_wdata_d;
   logic        ram_we_q, ram_we_d;
   logic        if_valid_q, if_valid_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;

   logic        if_pend;
   logic        mem_pend;
   logic        grant_if;
   logic        grant_mem;
   logic        starve_sat;

   // A requester is no longer pending in the cycle its completion pulse is
   // shown, so the same request is never granted twice.
   assign mem_pend = (MEM_MemRead | MEM_MemWrite) & ~mem_valid_q;
   assign if_pend  = if_req & ~if_valid_q;

   mem_arb_starve_cnt #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk(clk),
      .rst(rst),
      .inc(grant_mem & if_pend),
      .clr(grant_if),
      .sat(starve_sat)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: pick a requester from IDLE, return on ram_ready.
   always_comb begin
      state_d   = state_q;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_pend && !(if_pend && starve_sat)) begin
               state_d   = BUSY_MEM;
               grant_mem = 1'b1;
            end else if (if_pend) begin
               state_d  = BUSY_IF;
               grant_if = 1'b1;
            end
         end
         BUSY_IF, BUSY_MEM: begin
            if (ram_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: memory enable follows the busy states, stalls follow pend.
   always_comb begin
      ram_en    = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
      ram_we    = ram_we_q;
      ram_addr  = ram_addr_q;
      ram_wdata = ram_wdata_q;
      if_valid  = if_valid_q;
      mem_valid = mem_valid_q;
      if_rdata  = if_rdata_q;
      mem_rdata = mem_rdata_q;
      if_stall  = if_pend;
      mem_stall = mem_pend;
   end

   // Datapath next values: latch the granted request, capture read data on
   // completion. A simultaneous read+write is a write, so load data is kept.
   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = ram_we_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      if (grant_mem) begin
         ram_addr_d  = mem_addr;
         ram_wdata_d = mem_wdata;
         ram_we_d    = MEM_MemWrite;
      end else if (grant_if) begin
         ram_addr_d  = if_addr;
         ram_wdata_d = '0;
         ram_we_d    = 1'b0;
      end
      if ((state_q == BUSY_IF) && ram_ready) begin
         if_valid_d = 1'b1;
         if_rdata_d = ram_rdata;
      end
      if ((state_q == BUSY_MEM) && ram_ready) begin
         mem_valid_d = 1'b1;
         if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
         end
      end
   end

   // Datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        if_stall;
   logic        MEM_MemRead;
   logic        MEM_MemWrite;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        mem_stall;
   logic        ram_en;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ready;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(
      .STARVE_MAX(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_rdata(if_rdata),
      .if_valid(if_valid),
      .if_stall(if_stall),
      .MEM_MemRead(MEM_MemRead),
      .MEM_MemWrite(MEM_MemWrite),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_valid(mem_valid),
      .mem_stall(mem_stall),
      .ram_en(ram_en),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .ram_ready(ram_ready)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one full cycle: through the rising edge to the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++; if (ram_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_en: got %b expected 0", ram_en); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_we: got %b expected 0", ram_we); end
      checks++; if (ram_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_ram_addr: got %h expected 0", ram_addr); end
      checks++; if (if_valid !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b%b expected 00", if_valid, mem_valid); end
      checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h/%h expected 0/0", if_rdata, mem_rdata); end
      rst = 1'b0;
   endtask

   task automatic test_if_only();
      if_req = 1'b1; if_addr = 32'h100;
      #1;
      checks++; if (if_stall !== 1'b1) begin errors++; $display("[TB] FAIL ifonly_stall_comb: got %b expected 1", if_stall); end
      tick();
      checks++; if (ram_en !== 1'b1) begin errors++; $display("[TB] FAIL ifonly_ram_en: got %b expected 1", ram_en); end
      checks++; if (ram_addr !== 32'h100) begin errors++; $display("[TB] FAIL ifonly_ram_addr: got %h expected 00000100", ram_addr); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL ifonly_ram_we: got %b expected 0", ram_we); end
      ram_ready = 1'b1; ram_rdata = 32'h8C010004;
      tick();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL ifonly_valid: got %b expected 1", if_valid); end
      checks++; if (if_rdata !== 32'h8C010004) begin errors++; $display("[TB] FAIL ifonly_rdata: got %h expected 8c010004", if_rdata); end
      checks++; if (ram_en !== 1'b0 || if_stall !== 1'b0) begin errors++; $display("[TB] FAIL ifonly_done: got en=%b stall=%b expected 0 0", ram_en, if_stall); end
      ram_ready = 1'b0; if_req = 1'b0;
      tick();
      checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h8C010004) begin errors++; $display("[TB] FAIL ifonly_hold: got valid=%b rdata=%h expected 0 8c010004", if_valid, if_rdata); end
   endtask

   task automatic test_conflict();
      if_req = 1'b1; if_addr = 32'h200;
      MEM_MemWrite = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
      tick();
      checks++; if (ram_we !== 1'b1 || ram_addr !== 32'h40) begin errors++; $display("[TB] FAIL conf_mem_first: got we=%b addr=%h expected 1 00000040", ram_we, ram_addr); end
      checks++; if (ram_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL conf_wdata: got %h expected deadbeef", ram_wdata); end
      checks++; if (if_stall !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("[TB] FAIL conf_stalls: got %b%b expected 11", if_stall, mem_stall); end
      ram_ready = 1'b1; ram_rdata = 32'h11111111;
      tick();
      checks++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL conf_mem_done: got valid=%b rdata=%h expected 1 00000000", mem_valid, mem_rdata); end
      checks++; if (if_stall !== 1'b1) begin errors++; $display("[TB] FAIL conf_if_stall_held: got %b expected 1", if_stall); end
      MEM_MemWrite = 1'b0; ram_ready = 1'b0;
      tick();
      checks++; if (ram_en !== 1'b1 || ram_addr !== 32'h200 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL conf_if_next: got en=%b addr=%h we=%b expected 1 00000200 0", ram_en, ram_addr, ram_we); end
      ram_ready = 1'b1; ram_rdata = 32'hCAFEF00D;
      tick();
      checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL conf_if_done: got valid=%b rdata=%h expected 1 cafef00d", if_valid, if_rdata); end
      if_req = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   task automatic test_wait_states();
      ram_ready = 1'b1; ram_rdata = 32'hBADBAD00;
      tick();
      checks++; if (ram_en !== 1'b0 || if_valid !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready_ignored: got en=%b iv=%b mv=%b expected 000", ram_en, if_valid, mem_valid); end
      ram_ready = 1'b0;
      MEM_MemRead = 1'b1; mem_addr = 32'h80;
      tick();
      checks++; if (ram_en !== 1'b1 || ram_addr !== 32'h80 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL wait_grant: got en=%b addr=%h we=%b expected 1 00000080 0", ram_en, ram_addr, ram_we); end
      for (int i = 0; i < 5; i++) begin
         mem_addr = 32'h999 + i;
         tick();
         checks++; if (ram_en !== 1'b1 || ram_addr !== 32'h80 || mem_stall !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_cycle%0d: got en=%b addr=%h stall=%b valid=%b expected 1 00000080 1 0", i, ram_en, ram_addr, mem_stall, mem_valid); end
      end
      ram_ready = 1'b1; ram_rdata = 32'h12345678;
      tick();
      checks++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL wait_done: got valid=%b rdata=%h expected 1 12345678", mem_valid, mem_rdata); end
      MEM_MemRead = 1'b0; ram_ready = 1'b0;
      tick();
      checks++; if (mem_valid !== 1'b0 || mem_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL wait_hold: got valid=%b rdata=%h expected 0 12345678", mem_valid, mem_rdata); end
   endtask

   task automatic test_read_write_both();
      MEM_MemRead = 1'b1; MEM_MemWrite = 1'b1; mem_addr = 32'h44; mem_wdata = 32'hA5A5A5A5;
      tick();
      checks++; if (ram_we !== 1'b1 || ram_wdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL rw_is_write: got we=%b wdata=%h expected 1 a5a5a5a5", ram_we, ram_wdata); end
      ram_ready = 1'b1; ram_rdata = 32'hFFFFFFFF;
      tick();
      checks++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL rw_rdata_kept: got valid=%b rdata=%h expected 1 12345678", mem_valid, mem_rdata); end
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      for (int k = 0; k < 4; k++) begin
         if_req = 1'b1; if_addr = 32'h300;
         MEM_MemRead = 1'b1; mem_addr = 32'h500 + 32'(k * 4);
         tick();
         checks++; if (ram_addr !== 32'h500 + 32'(k * 4) || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL starve_mem_grant%0d: got addr=%h we=%b expected %h 0", k, ram_addr, ram_we, 32'h500 + 32'(k * 4)); end
         ram_ready = 1'b1; ram_rdata = 32'h1000 + 32'(k);
         tick();
         if_req = 1'b0; ram_ready = 1'b0;
         tick();
      end
      if_req = 1'b1; MEM_MemRead = 1'b1; mem_addr = 32'h600;
      tick();
      checks++; if (ram_addr !== 32'h300 || ram_en !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("[TB] FAIL starve_if_forced: got addr=%h en=%b mstall=%b expected 00000300 1 1", ram_addr, ram_en, mem_stall); end
      ram_ready = 1'b1; ram_rdata = 32'h0BADF00D;
      tick();
      checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL starve_if_done: got valid=%b rdata=%h expected 1 0badf00d", if_valid, if_rdata); end
      if_req = 1'b0; ram_ready = 1'b0;
      tick();
      checks++; if (ram_addr !== 32'h600 || ram_en !== 1'b1) begin errors++; $display("[TB] FAIL starve_mem_after: got addr=%h en=%b expected 00000600 1", ram_addr, ram_en); end
      ram_ready = 1'b1;
      tick();
      MEM_MemRead = 1'b0; ram_ready = 1'b0;
      tick();
      if_req = 1'b1; MEM_MemRead = 1'b1; mem_addr = 32'h700;
      tick();
      checks++; if (ram_addr !== 32'h700) begin errors++; $display("[TB] FAIL starve_cnt_cleared: got addr=%h expected 00000700", ram_addr); end
      ram_ready = 1'b1;
      tick();
      MEM_MemRead = 1'b0; ram_ready = 1'b0;
      tick();
      checks++; if (ram_addr !== 32'h300) begin errors++; $display("[TB] FAIL starve_if_after_conflict: got addr=%h expected 00000300", ram_addr); end
      ram_ready = 1'b1; ram_rdata = 32'h44556677;
      tick();
      if_req = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      MEM_MemWrite = 1'b1; mem_addr = 32'h88; mem_wdata = 32'h5555;
      tick();
      checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy: got en=%b we=%b expected 1 1", ram_en, ram_we); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL midrst_ram: got en=%b we=%b addr=%h wdata=%h expected 0 0 0 0", ram_en, ram_we, ram_addr, ram_wdata); end
      checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0 || if_valid !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_outputs: got ird=%h mrd=%h iv=%b mv=%b expected 0 0 0 0", if_rdata, mem_rdata, if_valid, mem_valid); end
      MEM_MemWrite = 1'b0;
      if_req = 1'b1; if_addr = 32'h404;
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++; if (ram_en !== 1'b1 || ram_addr !== 32'h404 || ram_we !== 1'b0) begin errors++; $display("[TB] FAIL midrst_first_grant: got en=%b addr=%h we=%b expected 1 00000404 0", ram_en, ram_addr, ram_we); end
      ram_ready = 1'b1; ram_rdata = 32'h00000077;
      tick();
      checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h77) begin errors++; $display("[TB] FAIL midrst_if_done: got valid=%b rdata=%h expected 1 00000077", if_valid, if_rdata); end
      if_req = 1'b0; ram_ready = 1'b0;
      tick();
   endtask

   // Test sequence.
   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; mem_addr = '0; mem_wdata = '0;
      ram_rdata = '0; ram_ready = 1'b0;
      test_reset();
      test_if_only();
      test_conflict();
      test_wait_states();
      test_read_write_both();
      test_starvation();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
